// File: rtl/cmd_frame_parser_pkg.sv
// Shared definitions for the FX2 command deframer: sync byte, FSM states and
// the command codes understood by the downstream dispatcher.
package cmd_frame_parser_pkg;

  localparam logic [7:0] CMD_SYNC       = 8'hAA;
  localparam logic [7:0] CMD_START_STOP = 8'h01;
  localparam logic [7:0] CMD_REG_WRITE  = 8'h04;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_CMD,
    ST_PAYLOAD,
    ST_HOLD
  } cmd_state_e;

endpackage

// File: rtl/cmd_payload_buf.sv
// Byte-addressed payload register file with synchronous clear, presented as
// one flat vector (byte i at bits [8i+7:8i]).
module cmd_payload_buf #(
  parameter int MAX_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 we,
  input  logic [3:0]           idx,
  input  logic [7:0]           wdata,
  output logic [8*MAX_LEN-1:0] data
);

  logic [7:0] mem_q [MAX_LEN];
  logic [7:0] mem_d [MAX_LEN];

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      mem_d[i] = mem_q[i];
      if (clr) begin
        mem_d[i] = 8'h00;
      end else if (we && (idx == 4'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      data[8*i +: 8] = mem_q[i];
    end
  end

endmodule

// File: rtl/cmd_frame_parser.sv
// FX2 command deframer: AA, LEN, CMD, payload -> held frame on a rdy/ack handshake.
// Optional mid-frame idle timeout is built when CMD_TIMEOUT_EN is defined.
module cmd_frame_parser
  import cmd_frame_parser_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 fx2_clk,
  input  logic                 reset_n,
  input  logic                 cmd_wr,
  input  logic [7:0]           cmd_in,
  output logic                 cmd_rdy,
  input  logic                 cmd_ack,
  output logic [7:0]           cmd,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_data,
  output logic                 frame_err,
  output logic                 overrun,
  output cmd_state_e           dbg_state
);

  // Handshake: cmd_rdy high means cmd/cmd_len/cmd_data are stable; the frame
  // is released on the first clock edge where cmd_rdy and cmd_ack are both 1.
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  cmd_state_e state_q, state_d;
  logic [3:0] len_q, len_d;
  logic [7:0] cmd_q, cmd_d;
  logic [3:0] idx_q, idx_d;
  logic       rdy_q, rdy_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       buf_clr, buf_we;

`ifdef CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);
  logic [15:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    rdy_d       = rdy_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    buf_clr     = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (cmd_wr && (cmd_in == CMD_SYNC)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (cmd_wr) begin
          if (cmd_in > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            state_d     = ST_HUNT;
          end else begin
            len_d   = cmd_in[3:0];
            idx_d   = 4'd0;
            buf_clr = 1'b1;
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (cmd_wr) begin
          cmd_d = cmd_in;
          if (len_q == 4'd0) begin
            rdy_d   = 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (cmd_wr) begin
          buf_we = 1'b1;
          idx_d  = idx_q + 4'd1;
          if (idx_q == len_q - 4'd1) begin
            rdy_d   = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cmd_ack) begin
          // The byte arriving alongside the ack is hunted, so back-to-back frames lose nothing.
          rdy_d   = 1'b0;
          state_d = (cmd_wr && (cmd_in == CMD_SYNC)) ? ST_LEN : ST_HUNT;
        end else if (cmd_wr) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_HUNT;
    endcase

`ifdef CMD_TIMEOUT_EN
    tmo_d = 16'd0;
    if ((state_q inside {ST_LEN, ST_CMD, ST_PAYLOAD}) && !cmd_wr) begin
      tmo_d = tmo_q + 16'd1;
      if (tmo_d == TMO_LIM) begin
        frame_err_d = 1'b1;
        state_d     = ST_HUNT;
        tmo_d       = 16'd0;
      end
    end
`endif
  end

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HUNT;
      len_q       <= 4'd0;
      cmd_q       <= 8'h00;
      idx_q       <= 4'd0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      idx_q       <= idx_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef CMD_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  cmd_payload_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_payload_buf (
    .clk   (fx2_clk),
    .rst_n (reset_n),
    .clr   (buf_clr),
    .we    (buf_we),
    .idx   (idx_q),
    .wdata (cmd_in),
    .data  (cmd_data)
  );

  assign cmd_rdy   = rdy_q;
  assign cmd       = cmd_q;
  assign cmd_len   = len_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Self-checking bench for cmd_frame_parser: directed frames, error/overrun
// cases, mid-frame reset, stall/timeout and a batch of random frames.
module tb_cmd_frame_parser;
  import cmd_frame_parser_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int TIMEOUT = 16;
  localparam int DW      = 8 * MAX_LEN;
  localparam int W       = 12 + DW;

  logic          fx2_clk;
  logic          reset_n;
  logic          cmd_wr;
  logic [7:0]    cmd_in;
  logic          cmd_rdy;
  logic          cmd_ack;
  logic [7:0]    cmd;
  logic [3:0]    cmd_len;
  logic [DW-1:0] cmd_data;
  logic          frame_err;
  logic          overrun;
  cmd_state_e    dbg_state;

  cmd_frame_parser #(
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .fx2_clk   (fx2_clk),
    .reset_n   (reset_n),
    .cmd_wr    (cmd_wr),
    .cmd_in    (cmd_in),
    .cmd_rdy   (cmd_rdy),
    .cmd_ack   (cmd_ack),
    .cmd       (cmd),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial fx2_clk = 1'b0;
  always #5 fx2_clk = ~fx2_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_cmp;
  int         n_bad;
  int         err_cnt;
  int         ovr_cnt;
  logic       rdy_seen;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge fx2_clk) begin
    if (reset_n) begin
      err_cnt += int'(frame_err);
      ovr_cnt += int'(overrun);
      if (cmd_rdy && !rdy_seen) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("frame_cmd", cmd, mon_e[W-1 -: 8]);
          check_eq("frame_len", cmd_len, mon_e[DW +: 4]);
          check_eq("frame_data", cmd_data, mon_e[DW-1:0]);
        end
      end
    end
    rdy_seen = cmd_rdy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge fx2_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmd_wr = 1'b1;
    cmd_in = b;
    tick();
    cmd_wr = 1'b0;
    cmd_in = 8'h00;
  endtask

  task automatic send_gap(input logic [7:0] b);
    idle($urandom_range(0, 2));
    send_byte(b);
  endtask

  task automatic send_list(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic do_ack();
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] c, input logic [3:0] l, input logic [DW-1:0] d);
    exp_q.push_back({c, l, d});
  endtask

  // ---------------- stimulus ----------------
  int            e0;
  int            o0;
  int            rlen;
  int            ngarb;
  logic [7:0]    rcmd;
  logic [7:0]    gb;
  logic [DW-1:0] rdata;

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    err_cnt  = 0;
    ovr_cnt  = 0;
    rdy_seen = 1'b0;
    reset_n  = 1'b0;
    cmd_wr   = 1'b0;
    cmd_in   = 8'h00;
    cmd_ack  = 1'b0;
    idle(3);
    check_eq("rst_rdy", cmd_rdy, 0);
    check_eq("rst_cmd", cmd, 0);
    check_eq("rst_len", cmd_len, 0);
    check_eq("rst_data", cmd_data, 0);
    check_eq("rst_err", frame_err, 0);
    check_eq("rst_ovr", overrun, 0);
    check_eq("rst_state", dbg_state, ST_HUNT);
    reset_n = 1'b1;
    idle(2);

    // Register write, 5-byte payload
    push_exp(8'h04, 4'd5, 64'h0000_0002_4000_0000);
    send_list('{8'hAA, 8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40});
    check_eq("rdy_early", cmd_rdy, 0);
    send_byte(8'h02);
    check_eq("rdy_latency", cmd_rdy, 1);
    idle(2);
    check_eq("rdy_hold", cmd_rdy, 1);
    do_ack();
    check_eq("rdy_drop", cmd_rdy, 0);

    // Short command, then back-to-back frame with sync on the ack cycle
    push_exp(8'h01, 4'd1, 64'h01);
    push_exp(8'h01, 4'd1, 64'h02);
    send_list('{8'hAA, 8'h01, 8'h01, 8'h01});
    check_eq("short_rdy", cmd_rdy, 1);
    cmd_ack = 1'b1;
    send_byte(8'hAA);
    cmd_ack = 1'b0;
    check_eq("b2b_rdy_drop", cmd_rdy, 0);
    send_list('{8'h01, 8'h01});
    send_byte(8'h02);
    check_eq("b2b_rdy", cmd_rdy, 1);
    do_ack();

    // Garbage and oversize length
    e0 = err_cnt;
    send_list('{8'h13, 8'h37, 8'hAA, 8'h09});
    idle(2);
    check_eq("oversize_err_cnt", err_cnt, e0 + 1);
    check_eq("oversize_state", dbg_state, ST_HUNT);
    push_exp(8'h07, 4'd0, 64'h0);
    send_list('{8'hAA, 8'h00, 8'h07});
    check_eq("len0_rdy", cmd_rdy, 1);
    do_ack();

    // Overrun while holding; AA inside payload is data
    push_exp(8'h04, 4'd2, 64'hAA11);
    send_list('{8'hAA, 8'h02, 8'h04, 8'h11, 8'hAA});
    check_eq("ovr_frame_rdy", cmd_rdy, 1);
    o0 = ovr_cnt;
    send_list('{8'h55, 8'h66, 8'h77});
    idle(1);
    check_eq("ovr_cnt", ovr_cnt, o0 + 3);
    check_eq("ovr_cmd", cmd, 8'h04);
    check_eq("ovr_data", cmd_data, 64'hAA11);
    check_eq("ovr_rdy", cmd_rdy, 1);
    do_ack();

    // Reset mid-frame
    send_list('{8'hAA, 8'h05, 8'h04, 8'h00});
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_cmd", cmd, 0);
    check_eq("mid_rst_len", cmd_len, 0);
    check_eq("mid_rst_data", cmd_data, 0);
    check_eq("mid_rst_rdy", cmd_rdy, 0);
    check_eq("mid_rst_state", dbg_state, ST_HUNT);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    push_exp(8'h02, 4'd0, 64'h0);
    send_list('{8'hAA, 8'h00, 8'h02});
    check_eq("post_rst_rdy", cmd_rdy, 1);
    do_ack();

`ifdef CMD_TIMEOUT_EN
    e0 = err_cnt;
    send_list('{8'hAA, 8'h02});
    idle(15);
    check_eq("tmo_early", frame_err, 0);
    idle(1);
    check_eq("tmo_pulse", frame_err, 1);
    check_eq("tmo_state", dbg_state, ST_HUNT);
    send_byte(8'h05);
    idle(2);
    check_eq("tmo_err_cnt", err_cnt, e0 + 1);
    check_eq("tmo_late_cmd", dbg_state, ST_HUNT);
`else
    e0 = err_cnt;
    push_exp(8'h09, 4'd2, 64'h0201);
    send_list('{8'hAA, 8'h02});
    idle(20);
    check_eq("stall_state", dbg_state, ST_CMD);
    send_list('{8'h09, 8'h01});
    send_byte(8'h02);
    check_eq("stall_rdy", cmd_rdy, 1);
    check_eq("stall_no_err", err_cnt, e0);
    do_ack();
`endif

    // Random frames with garbage prefixes and inter-byte gaps
    for (int f = 0; f < 8; f++) begin
      rlen  = $urandom_range(0, MAX_LEN);
      rcmd  = 8'($urandom_range(0, 255));
      ngarb = $urandom_range(0, 3);
      rdata = '0;
      for (int i = 0; i < rlen; i++) rdata[8*i +: 8] = 8'($urandom_range(0, 255));
      push_exp(rcmd, 4'(rlen), rdata);
      for (int g = 0; g < ngarb; g++) begin
        gb = 8'($urandom_range(0, 255));
        if (gb == CMD_SYNC) gb = 8'h55;
        send_gap(gb);
      end
      send_gap(CMD_SYNC);
      send_gap(8'(rlen));
      send_gap(rcmd);
      for (int i = 0; i < rlen; i++) send_gap(rdata[8*i +: 8]);
      check_eq("rand_rdy", cmd_rdy, 1);
      idle($urandom_range(0, 3));
      do_ack();
      check_eq("rand_rdy_drop", cmd_rdy, 0);
    end

    idle(2);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Byte-stream command deframer in the `fx2_clk` domain. Sits between the FX2 command write port (`cmd_wr`/`cmd_in`) and the command dispatcher. It hunts for the sync byte, collects one length-prefixed frame, and presents the decoded command code and payload on a ready/ack handshake. Malformed frames are discarded and flagged.

## Interface
- `MAX_LEN`, 8: maximum payload bytes per frame (1..15).
- `TIMEOUT`, 255: idle `fx2_clk` cycles mid-frame before abort (only with `CMD_TIMEOUT_EN`).
- `fx2_clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous assert, active low; deassertion synchronous to `fx2_clk` externally.
- `cmd_wr` in 1: `cmd_in` valid this cycle; one byte per cycle.
- `cmd_in` in 8: command byte.
- `cmd_rdy` out 1: frame held on outputs.
- `cmd_ack` in 1: consumer has taken the frame.
- `cmd` out 8: command code.
- `cmd_len` out 4: payload byte count.
- `cmd_data` out 8*MAX_LEN: payload; byte i at bits [8i+7:8i].
- `frame_err` out 1: one-cycle pulse on discard of a malformed frame.
- `overrun` out 1: one-cycle pulse on a byte dropped while holding.

## Operation
- Frame layout: `0xAA`, LEN (payload count), CMD, then LEN payload bytes. LEN=0 is legal.
- State machine states:
  - HUNT: on `cmd_wr` with `0xAA`, go to LEN. Other bytes are ignored silently.
  - LEN: on `cmd_wr`:
    - byte > MAX_LEN: pulse `frame_err`, go to HUNT.
    - otherwise: latch count, go to CMD.
  - CMD: on `cmd_wr`, latch `cmd`. Go to HOLD if LEN=0, else go to PAYLOAD.
  - PAYLOAD: each `cmd_wr` stores the byte at index `idx` (starting at 0), then increments `idx`. After byte LEN-1 is stored, go to HOLD.
  - HOLD: `cmd_rdy`=1 and outputs are stable.
    - `cmd_ack`=1: next state HUNT, and an incoming byte that same cycle is processed as in HUNT.
    - `cmd_ack`=0 with a `cmd_wr` byte: byte dropped, `overrun` pulses.
- Unused `cmd_data` bytes beyond `cmd_len` are zero. The buffer is cleared on entry to CMD.
- `cmd_ack` outside HOLD is ignored.
- A `0xAA` byte inside a frame is data. There is no resync mid-frame.
- Reset mid-operation: all state is discarded immediately and the block returns to HUNT.

## Timing
- Reset values: `cmd_rdy`=0, `cmd`=0, `cmd_len`=0, `cmd_data`=0, `frame_err`=0, `overrun`=0, state HUNT.
- All outputs are registered.
- `cmd_rdy` rises on the edge that samples the last frame byte (CMD if LEN=0, else the final payload byte). It is visible the following cycle.
- Minimum frame-to-ready latency is LEN+3 cycles of `cmd_wr` from the sync byte.
- `cmd_rdy` falls on the edge sampling `cmd_ack`=1.
- Back-to-back frames with ack asserted in the first HOLD cycle lose no bytes.
- `frame_err` and `overrun` are high for exactly one cycle per event.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - In LEN, CMD or PAYLOAD, a counter increments on each cycle with `cmd_wr`=0 and clears on `cmd_wr`=1.
  - On reaching TIMEOUT, pulse `frame_err` and go to HUNT.
  - The counter is reset in HUNT and HOLD.
- `CMD_TIMEOUT_EN` undefined: no counter, and stalled frames wait indefinitely. The `TIMEOUT` parameter is unused.

## Structure
- Shared package holds:
  - `CMD_SYNC` = 8'hAA.
  - The state enum (HUNT, LEN, CMD, PAYLOAD, HOLD).
  - Command code constants used by the dispatcher: 8'h01 start/stop, 8'h04 register write.
- One natural sub-module: `cmd_payload_buf`. It is a byte-addressed MAX_LEN register file with clear, write-enable and index, flattened to `cmd_data`.
- The state machine and the optional timeout counter stay in the top.

## Test plan
- Sync, register write: bytes AA 05 04 00 00 00 40 02 on consecutive cycles -> `cmd_rdy`=1 one cycle after 02 sampled; `cmd`=04, `cmd_len`=5, `cmd_data[39:0]`=40'h0240000000; upper bytes zero.
- Short command plus ack: AA 01 01 01, then `cmd_ack` pulse -> `cmd`=01, `cmd_len`=1, `cmd_data[7:0]`=01; `cmd_rdy` drops the cycle after ack. A second frame AA 01 01 02 sent right after is decoded as 02.
- Garbage and oversize: 13 37 AA 09 ... with MAX_LEN=8 -> leading bytes ignored; `frame_err` pulses once on 09; next AA 00 07 yields `cmd`=07, `cmd_len`=0.
- Overrun: frame held with no ack, then 3 extra bytes -> `overrun` pulses 3 times; `cmd`/`cmd_data` unchanged.
- Reset mid-frame: `reset_n` low after AA 05 04 00 -> all outputs 0 at once; a following AA 00 02 decodes cleanly.
- With `CMD_TIMEOUT_EN`, TIMEOUT=16: AA 02, then idle for 16 cycles -> `frame_err` pulse, HUNT. A late CMD byte is ignored.
